ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

AHB-Lite on-chip SRAM slave that sits downstream of the bus interconnect in slot 0 of the slave map, which covers bytes 0 to 2047. It takes the shared address/control/write-data fan-out and its own select line. It returns read data, `ready` and response to the interconnect's read mux. The data phase can be stretched by a programmable number of wait states. Byte, halfword and word accesses are supported. Misaligned or oversized transfers get a two-cycle ERROR response.

## Interface
Parameters:
- `DEPTH_WORDS`, 512: number of 32-bit words. The byte capacity is `DEPTH_WORDS*4`, which matches the 2048-byte map slot.
- `WAIT_STATES`, 0: number of `ready_out`-low cycles inserted in every OKAY data phase. Legal range is 0..7.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sel`  in  1  slave select from the address decoder.
- `write`  in  1  1 = write transfer.
- `addr`  in  32  byte address. Only bits `[$clog2(DEPTH_WORDS)+1:0]` are used.
- `size`  in  3  0 = byte, 1 = halfword, 2 = word, 3..7 = illegal.
- `burst`  in  3  burst type. Ignored; every beat is handled as an independent transfer.
- `prot`  in  4  protection. Ignored.
- `trans`  in  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ.
- `mastlock`  in  1  locked transfer. Ignored.
- `ready`  in  1  bus-level ready (the previous transfer has completed).
- `wdata`  in  32  write data, valid in the data phase.
- `rdata`  out  32  read data.
- `ready_out`  out  1  slave ready.
- `resp`  out  1  0 = OKAY, 1 = ERROR.

## Operation
- **Address-phase accept.** A transfer is accepted on a rising edge where `sel & ready & trans[1]` is true. On acceptance, `write`, the word index `addr[..:2]`, the byte offset `addr[1:0]` and `size` are registered.
- **Ignored transfers.** IDLE or BUSY, or `sel` low, produce no data phase and leave `ready_out`=1, `resp`=0.
- **Legality check.** An accepted transfer is legal when `size`≤2 and the address is aligned:
  - halfword: `addr[0]`=0
  - word: `addr[1:0]`=0

  Any other transfer is illegal.
- **State machine** (states IDLE, WAIT, DATA, ERR1, ERR2):
  - **IDLE:** `ready_out`=1, `resp`=0. On a legal accept, go to WAIT if `WAIT_STATES`>0, otherwise DATA. On an illegal accept, go to ERR1.
  - **WAIT:** `ready_out`=0, `resp`=0. A down-counter is loaded with `WAIT_STATES`. When it reaches 1, go to DATA.
  - **DATA:** `ready_out`=1, `resp`=0. The transfer completes on this edge.
    - Write: the byte lanes selected by size/offset are written from `wdata` (little-endian: lane k = `wdata[8k+7:8k]`).
    - Read: `rdata` = the full addressed word, combinational from the array using the registered index.
    - If a new transfer is accepted on the same edge, the next state follows the IDLE rules; otherwise go to IDLE.
  - **ERR1:** `ready_out`=0, `resp`=1. Always go to ERR2.
  - **ERR2:** `ready_out`=1, `resp`=1. The array is not touched. New-accept handling is the same as in DATA.
- **Pipelining.** A new address phase may overlap the completing data phase (DATA or ERR2). No new accept happens in WAIT or ERR1, because the bus `ready` is low during those states.
- **Read-after-write.** A read whose address phase overlaps a write's DATA cycle to the same word must return the newly written bytes. The array is written at the end of DATA and read during the following data phase, so this holds with no forwarding logic.
- **`rdata` outside a read.** `rdata` = 0 in every cycle that is not a read in DATA.
- **Address range.** Upper address bits are not decoded (the decoder guarantees range), so the index wraps modulo `DEPTH_WORDS`.

## Timing
- **Reset values:** state IDLE, wait counter 0, `ready_out`=1, `resp`=0, `rdata`=0. Array contents are not cleared.
- **Reset during WAIT/DATA/ERR:** the pending transfer is abandoned. A pending write does not modify the array.
- **Zero-wait latency:** address phase in cycle N, data phase in N+1 with `ready_out`=1. Back-to-back transfers give one beat per cycle.
- **With `WAIT_STATES`=W:** `ready_out` is low in cycles N+1..N+W and high in N+W+1. Write commit and read data both occur in N+W+1.
- **Error:** `resp`=1 with `ready_out`=0 in N+1, then `resp`=1 with `ready_out`=1 in N+2.
- **`resp` timing:** `resp` returns to 0 in the cycle after ERR2 unless a new illegal transfer was accepted in ERR2.

## Test plan
- **Reset, then idle:** hold `reset` 2 cycles, then drive `trans`=0 for 5 cycles → `ready_out`=1, `resp`=0, `rdata`=0 every cycle.
- **Word write then read (W=0):** write 0xDEADBEEF to 0x010, then immediately read 0x010 in the overlapping address phase → `rdata`=0xDEADBEEF one cycle later, `ready_out` never low.
- **Byte lanes:** word write 0x11223344 to 0x020, byte write 0xAA to 0x022, halfword write 0xBBCC to 0x020, then word read → `rdata`=0x11AABBCC.
- **Wait states (W=2):** read 0x000 → `ready_out` low for exactly 2 cycles, then high with valid data. A second queued NONSEQ is accepted only on the completing edge.
- **Errors:** halfword write at 0x003 and a `size`=3 read → each gives the ERR1/ERR2 sequence (`ready_out` 0 then 1, `resp` 1 both cycles), and a follow-up read of word 0x000 is unchanged.
- **Reset mid-write (W=3):** assert `reset` during the second WAIT cycle of a write of 0x55 to 0x040 → outputs return to reset values next cycle, and a later read of 0x040 returns the prior contents.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: byte/halfword/word access, programmable wait states,
// two-cycle ERROR response for misaligned or oversized transfers.
module ahb_sram_slave #(
  parameter int DEPTH_WORDS = 512,
  parameter int WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sel,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [2:0]  burst,
  input  logic [3:0]  prot,
  input  logic [1:0]  trans,
  input  logic        mastlock,
  input  logic        ready,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready_out,
  output logic        resp
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;

  // Handshake: an address phase is taken on a rising edge where sel, bus
  // ready and trans[1] are all high; the data phase ends on the edge where
  // ready_out is high. state_q is the observable FSM state.
  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      size_q, size_d;

  logic [31:0]     mem [DEPTH_WORDS];
  logic            accept;
  logic            legal;
  logic            we;
  logic [3:0]      be;

  logic unused_ok;
  assign unused_ok = ^{burst, prot, mastlock, trans[0], addr[31:AW+2]};

  assign accept = sel & ready & trans[1] &
                  ((state_q == S_IDLE) | (state_q == S_DATA) | (state_q == S_ERR2));
  assign legal  = (size == 3'd0) |
                  ((size == 3'd1) & ~addr[0]) |
                  ((size == 3'd2) & (addr[1:0] == 2'b00));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q <= 3'd1) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 share the accept rules so beats can pipeline.
        state_d = S_IDLE;
        if (accept) begin
          write_d = write;
          idx_d   = addr[AW+1:2];
          off_d   = addr[1:0];
          size_d  = size;
          if (!legal) begin
            state_d = S_ERR1;
          end else if (WS != 3'd0) begin
            state_d = S_WAIT;
            cnt_d   = WS;
          end else begin
            state_d = S_DATA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    be = 4'b0000;
    case (size_q)
      3'd0:    be = 4'b0001 << off_q;
      3'd1:    be = 4'b0011 << off_q;
      default: be = 4'b1111;
    endcase
  end

  // A reset landing on the DATA edge abandons the write.
  assign we = (state_q == S_DATA) & write_q & ~reset;

  always_ff @(posedge clock) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx_q][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata     = ((state_q == S_DATA) && !write_q) ? mem[idx_q] : '0;
  assign ready_out = !((state_q == S_WAIT) || (state_q == S_ERR1));
  assign resp      = (state_q == S_ERR1) || (state_q == S_ERR2);

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: three instances (0, 2 and 3 wait states) driven by
// a pipelined bus master, checked by a scoreboard against a word-array model.
module tb_ahb_sram_slave;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  sel_v;
  logic        write;
  logic [31:0] addr;
  logic [2:0]  size;
  logic [1:0]  trans;
  logic [31:0] wdata;
  logic        ready_bus;
  logic [31:0] rd0, rd2, rd3;
  logic        ro0, ro2, ro3, rs0, rs2, rs3;
  logic [31:0] rd [3];
  logic        ro [3];
  logic        rs [3];
  int          act = 0;
  int          ws_of [3] = '{0, 2, 3};

  typedef struct {
    logic        write;
    logic        err;
    int          idx;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          waits;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_m;
  logic [31:0] mdl [3][32];
  int          errors = 0;
  int          checks = 0;
  int          wcnt = 0;

  always #5 clock = ~clock;

  always_comb begin
    rd[0] = rd0; rd[1] = rd2; rd[2] = rd3;
    ro[0] = ro0; ro[1] = ro2; ro[2] = ro3;
    rs[0] = rs0; rs[1] = rs2; rs[2] = rs3;
  end
  assign ready_bus = ro[act];

  ahb_sram_slave #(.DEPTH_WORDS(512), .WAIT_STATES(0)) u_w0 (
    .clock(clock), .reset(reset), .sel(sel_v[0]), .write(write), .addr(addr),
    .size(size), .burst(3'b001), .prot(4'h3), .trans(trans), .mastlock(1'b0),
    .ready(ready_bus), .wdata(wdata), .rdata(rd0), .ready_out(ro0), .resp(rs0));
  ahb_sram_slave #(.DEPTH_WORDS(512), .WAIT_STATES(2)) u_w2 (
    .clock(clock), .reset(reset), .sel(sel_v[1]), .write(write), .addr(addr),
    .size(size), .burst(3'b001), .prot(4'h3), .trans(trans), .mastlock(1'b0),
    .ready(ready_bus), .wdata(wdata), .rdata(rd2), .ready_out(ro2), .resp(rs2));
  ahb_sram_slave #(.DEPTH_WORDS(512), .WAIT_STATES(3)) u_w3 (
    .clock(clock), .reset(reset), .sel(sel_v[2]), .write(write), .addr(addr),
    .size(size), .burst(3'b001), .prot(4'h3), .trans(trans), .mastlock(1'b0),
    .ready(ready_bus), .wdata(wdata), .rdata(rd3), .ready_out(ro3), .resp(rs3));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s (dut %0d, t=%0t): got %h expected %h", name, act, $time, got, want);
    end
  endtask

  // Present one address phase, hold it until accepted, then drive its write data.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd);
    exp_t e;
    logic r;
    int   n;
    int   off;
    sel_v      = 3'b000;
    sel_v[act] = 1'b1;
    trans      = 2'd2;
    write      = wr;
    addr       = a;
    size       = sz;
    n          = 0;
    do begin
      @(negedge clock);
      r = ready_bus;
      @(posedge clock);
      n++;
    end while (!r && n < 50);
    #1;
    sel_v = 3'b000;
    trans = 2'd0;
    if (!r) begin
      check("accept_timeout", 32'(n), 32'd0);
      return;
    end
    off     = int'(a[1:0]);
    e.write = wr;
    e.err   = !((sz <= 3'd2) && ((off % (1 << sz)) == 0));
    e.idx   = int'((a >> 2) % 512);
    e.be    = 4'b0000;
    if (!e.err) for (int b = 0; b < (1 << sz); b++) e.be[off + b] = 1'b1;
    e.wdata = wd;
    e.waits = e.err ? 1 : ws_of[act];
    exp_q.push_back(e);
    wdata = wd;
  endtask

  task automatic idle(input int n);
    sel_v = 3'b000;
    trans = 2'd0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clock);
      n++;
    end
    #1;
    if (exp_q.size() > 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every cycle is either idle or part of the head transfer's data phase.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      wcnt = 0;
    end else if (exp_q.size() == 0) begin
      check("idle_ready", 32'(ro[act]), 32'd1);
      check("idle_resp", 32'(rs[act]), 32'd0);
      check("idle_rdata", rd[act], 32'd0);
      wcnt = 0;
    end else begin
      e_m = exp_q[0];
      if (!ro[act]) begin
        wcnt++;
        check("stall_resp", 32'(rs[act]), 32'(e_m.err));
        check("stall_rdata", rd[act], 32'd0);
        if (wcnt > e_m.waits) check("stall_len", 32'(wcnt), 32'(e_m.waits));
      end else begin
        check("wait_cycles", 32'(wcnt), 32'(e_m.waits));
        check("resp", 32'(rs[act]), 32'(e_m.err));
        if (!e_m.err && !e_m.write) begin
          check("rdata", rd[act], mdl[act][e_m.idx]);
        end else begin
          check("rdata_zero", rd[act], 32'd0);
        end
        if (!e_m.err && e_m.write) begin
          for (int k = 0; k < 4; k++)
            if (e_m.be[k]) mdl[act][e_m.idx][8*k +: 8] = e_m.wdata[8*k +: 8];
        end
        void'(exp_q.pop_front());
        wcnt = 0;
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    reset = 1'b1;
    sel_v = 3'b000;
    trans = 2'd0;
    write = 1'b0;
    addr  = '0;
    size  = '0;
    wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    idle(5);

    // Known contents in words 0..31 of every instance, back-to-back.
    for (int d = 0; d < 3; d++) begin
      act = d;
      for (int i = 0; i < 32; i++) issue(1'b1, 32'(i) << 2, 3'd2, $urandom);
      drain();
    end

    act = 0;
    issue(1'b1, 32'h010, 3'd2, 32'hDEADBEEF);
    issue(1'b0, 32'h010, 3'd2, 32'h0);
    issue(1'b1, 32'h020, 3'd2, 32'h11223344);
    issue(1'b1, 32'h022, 3'd0, 32'h00AA0000);
    issue(1'b1, 32'h020, 3'd1, 32'h0000BBCC);
    issue(1'b0, 32'h020, 3'd2, 32'h0);
    issue(1'b1, 32'h003, 3'd1, 32'hFFFFFFFF);
    issue(1'b0, 32'h000, 3'd3, 32'h0);
    issue(1'b1, 32'h000, 3'd7, 32'hFFFFFFFF);
    issue(1'b0, 32'h000, 3'd2, 32'h0);
    drain();

    act = 1;
    issue(1'b0, 32'h000, 3'd2, 32'h0);
    issue(1'b0, 32'h004, 3'd2, 32'h0);
    issue(1'b1, 32'h002, 3'd2, 32'h12345678);
    issue(1'b0, 32'h000, 3'd2, 32'h0);
    drain();

    // Reset lands in the second WAIT cycle of a byte write.
    act = 2;
    issue(1'b1, 32'h040, 3'd0, 32'h00000055);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(2);
    issue(1'b0, 32'h040, 3'd2, 32'h0);
    drain();

    for (int d = 0; d < 3; d++) begin
      act = d;
      for (int i = 0; i < 40; i++) begin
        sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        a  = (32'($urandom_range(0, 7)) << 11) | (32'($urandom_range(0, 31)) << 2) |
             32'($urandom_range(0, 3));
        issue(1'($urandom_range(0, 1)), a, sz, $urandom);
        if ($urandom_range(0, 4) == 0) idle(1);
      end
      drain();
      idle(2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
